// File: rtl/sort_seq_ctrl.sv
// Sort sequencer: gathers a batch, launches the external sorter,
// waits for its result with a timeout and streams it out with an order check.
module sort_seq_ctrl #(
  parameter int    DATA_WIDTH = 64,
  parameter int    DATA_CNT   = 16,
  parameter string COM_STYLE  = "UP",
  parameter int    TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] write_data [DATA_CNT],
  input  logic                  compare_en,
  input  logic [DATA_WIDTH-1:0] compare_data [DATA_CNT],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  order_err,
  output logic                  timeout_err
);

  localparam int IW = $clog2(DATA_CNT);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam bit DOWN = (COM_STYLE == "DOWN");
  localparam logic [IW-1:0] LAST = IW'(DATA_CNT - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    LOAD,
    ISSUE,
    WAIT,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0]         ld_idx;
  logic [IW-1:0]         out_idx;
  logic [TW-1:0]         tmo_cnt;
  logic [DATA_WIDTH-1:0] result [DATA_CNT];
  logic [DATA_WIDTH-1:0] prev;

  logic in_fire;
  logic out_fire;
  logic last_in;
  logic tmo_hit;
  logic bad_order;

  assign in_ready  = (state == LOAD);
  assign write_en  = (state == ISSUE);
  assign out_valid = (state == DRAIN);
  assign out_data  = result[out_idx];
  assign out_last  = out_valid && (out_idx == LAST);
  assign busy      = (state != LOAD) || (ld_idx != '0);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_in  = (ld_idx == LAST);
  // The cycle that would bring the count to TIMEOUT is the abort cycle.
  assign tmo_hit  = (tmo_cnt == TLIM);

  assign bad_order = DOWN ? (out_data > prev) : (out_data < prev);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (in_fire && last_in) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT: begin
        if (compare_en)   state_nx = DRAIN;
        else if (tmo_hit) state_nx = LOAD;
      end
      DRAIN:   if (out_fire && out_last) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_idx      <= '0;
      out_idx     <= '0;
      tmo_cnt     <= '0;
      prev        <= '0;
      order_err   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < DATA_CNT; i++) begin
        write_data[i] <= '0;
        result[i]     <= '0;
      end
    end else begin
      if (in_fire) begin
        write_data[ld_idx] <= in_data;
        ld_idx <= last_in ? '0 : ld_idx + IW'(1);
      end

      if (state == ISSUE) tmo_cnt <= '0;
      else if (state == WAIT && !compare_en) tmo_cnt <= tmo_cnt + TW'(1);

      if (state == WAIT) begin
        if (compare_en) begin
          result <= compare_data;
        end else if (tmo_hit) begin
          timeout_err <= 1'b1;
          ld_idx      <= '0;
        end
      end

      // Index 0 starts a batch, so no cross-batch comparison happens.
      if (out_fire) begin
        prev <= out_data;
        if (out_idx != '0 && bad_order) order_err <= 1'b1;
        out_idx <= out_last ? '0 : out_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Bench for sort_seq_ctrl: directed scenarios plus randomized batches
// checked against a queue-based model of the batch/handshake rules.
module tb_sort_seq_ctrl;

  localparam int DW = 8;
  localparam int DC = 4;
  localparam int TO = 8;

  typedef logic [DW-1:0] word_t;
  typedef word_t batch_t [DC];

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  in_valid = 1'b0;
  logic  in_ready;
  word_t in_data = '0;
  logic  write_en;
  word_t write_data [DC];
  logic  compare_en = 1'b0;
  word_t compare_data [DC];
  logic  out_valid;
  logic  out_ready = 1'b0;
  word_t out_data;
  logic  out_last;
  logic  busy;
  logic  order_err;
  logic  timeout_err;

  int vecs = 0;
  int errs = 0;

  word_t got_q [$];
  bit    last_q [$];
  bit    done;

  always #5 clk = ~clk;

  sort_seq_ctrl #(
    .DATA_WIDTH(DW),
    .DATA_CNT(DC),
    .COM_STYLE("UP"),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .write_en(write_en),
    .write_data(write_data),
    .compare_en(compare_en),
    .compare_data(compare_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy),
    .order_err(order_err),
    .timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    compare_en = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic load_batch(input batch_t b);
    for (int i = 0; i < DC; i++) begin
      in_valid = 1'b1;
      in_data = b[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  // d = WAIT cycle (1-based) on which compare_en is offered
  task automatic launch(input batch_t b, input batch_t cd, input int d);
    load_batch(b);
    step();
    for (int c = 1; c < d; c++) step();
    compare_en = 1'b1;
    compare_data = cd;
    step();
    compare_en = 1'b0;
  endtask

  task automatic collect(input bit stall);
    bit hs;
    bit lst;
    got_q.delete();
    last_q.delete();
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      hs = out_valid && out_ready;
      lst = out_last;
      if (hs) begin
        got_q.push_back(out_data);
        last_q.push_back(lst);
      end
      step();
      if (hs && lst) done = 1'b1;
    end
    out_ready = 1'b0;
  endtask

  function automatic bit viol_n(input batch_t w, input int n);
    for (int i = 1; i < n; i++)
      if (w[i] < w[i-1]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit stream_ok(input batch_t cd);
    if (got_q.size() != DC) return 1'b0;
    for (int i = 0; i < DC; i++) begin
      if (got_q[i] !== cd[i]) return 1'b0;
      if (last_q[i] !== (i == DC - 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit wd_ok(input batch_t b);
    for (int i = 0; i < DC; i++)
      if (write_data[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic batch_t rand_batch();
    batch_t b;
    for (int i = 0; i < DC; i++) b[i] = word_t'($urandom);
    return b;
  endfunction

  function automatic batch_t sorted(input batch_t b);
    word_t q [$];
    batch_t r;
    for (int i = 0; i < DC; i++) q.push_back(b[i]);
    q.sort();
    for (int i = 0; i < DC; i++) r[i] = q[i];
    return r;
  endfunction

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    vecs++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || write_en !== 1'b0) begin
      errs++;
      $display("FAIL reset_out: ov=%b ol=%b we=%b want 0 0 0",
               out_valid, out_last, write_en);
    end
    vecs++;
    if (order_err !== 1'b0 || timeout_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: oe=%b te=%b want 0 0", order_err, timeout_err);
    end
    vecs++;
    if (!wd_ok('{default: '0})) begin
      errs++;
      $display("FAIL reset_wdata: got %p want zeros", write_data);
    end
    step();
  endtask

  task automatic test_basic();
    batch_t b  = '{8'd3, 8'd1, 8'd2, 8'd0};
    batch_t cd = '{8'd0, 8'd1, 8'd2, 8'd3};
    load_batch(b);
    @(negedge clk);
    vecs++;
    if (write_en !== 1'b1) begin
      errs++;
      $display("FAIL basic_we_issue: got %b want 1", write_en);
    end
    vecs++;
    if (!wd_ok(b)) begin
      errs++;
      $display("FAIL basic_wdata: got %p want %p", write_data, b);
    end
    step();
    @(negedge clk);
    vecs++;
    if (write_en !== 1'b0) begin
      errs++;
      $display("FAIL basic_we_width: got %b want 0", write_en);
    end
    step();
    compare_en = 1'b1;
    compare_data = cd;
    step();
    compare_en = 1'b0;
    collect(1'b0);
    vecs++;
    if (!done || !stream_ok(cd)) begin
      errs++;
      $display("FAIL basic_stream: got %p want %p", got_q, cd);
    end
    @(negedge clk);
    vecs++;
    if (order_err !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_end: oe=%b rdy=%b busy=%b want 0 1 0",
               order_err, in_ready, busy);
    end
    step();
  endtask

  task automatic test_stall();
    batch_t b  = '{8'd40, 8'd10, 8'd30, 8'd20};
    batch_t cd = sorted(b);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n = 0;
    bit hs;
    launch(b, cd, 1);
    for (int c = 0; c < 40 && n < DC; c++) begin
      out_ready = pat[c % 4];
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b1 || out_data !== cd[n] || out_last !== (n == DC - 1)) begin
        errs++;
        $display("FAIL stall_word: ov=%b data=%h last=%b want 1 %h %b",
                 out_valid, out_data, out_last, cd[n], (n == DC - 1));
      end
      hs = out_ready;
      step();
      if (hs) n++;
    end
    out_ready = 1'b0;
    vecs++;
    if (n != DC) begin
      errs++;
      $display("FAIL stall_count: got %0d want %0d", n, DC);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL stall_extra: out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_order();
    batch_t b  = '{8'd2, 8'd0, 8'd3, 8'd1};
    batch_t cd = '{8'd0, 8'd2, 8'd1, 8'd3};
    int n = 0;
    launch(b, cd, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && n < DC; c++) begin
      @(negedge clk);
      vecs++;
      if (order_err !== viol_n(cd, n)) begin
        errs++;
        $display("FAIL order_flag@%0d: got %b want %b", n, order_err, viol_n(cd, n));
      end
      step();
      n++;
    end
    out_ready = 1'b0;
    @(negedge clk);
    vecs++;
    if (order_err !== 1'b1) begin
      errs++;
      $display("FAIL order_set: got %b want 1", order_err);
    end
    step();
    b = rand_batch();
    cd = sorted(b);
    launch(b, cd, 3);
    collect(1'b0);
    vecs++;
    if (!done || !stream_ok(cd)) begin
      errs++;
      $display("FAIL order_clean_stream: got %p want %p", got_q, cd);
    end
    @(negedge clk);
    vecs++;
    if (order_err !== 1'b1) begin
      errs++;
      $display("FAIL order_sticky: got %b want 1", order_err);
    end
    step();
  endtask

  task automatic test_timeout();
    batch_t b  = rand_batch();
    batch_t cd = sorted(b);
    load_batch(b);
    step();
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      vecs++;
      if (timeout_err !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL tmo_wait%0d: te=%b busy=%b rdy=%b want 0 1 0",
                 c, timeout_err, busy, in_ready);
      end
      step();
    end
    @(negedge clk);
    vecs++;
    if (timeout_err !== 1'b1) begin
      errs++;
      $display("FAIL tmo_flag: got %b want 1", timeout_err);
    end
    vecs++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL tmo_state: rdy=%b ov=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    step();
    compare_en = 1'b1;
    compare_data = cd;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL tmo_late_cmp: ov=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      step();
    end
    compare_en = 1'b0;
  endtask

  task automatic test_issue_ignore();
    batch_t b  = rand_batch();
    batch_t cd = sorted(b);
    bit seen = 1'b0;
    apply_reset();
    load_batch(b);
    compare_en = 1'b1;
    compare_data = cd;
    step();
    compare_en = 1'b0;
    for (int c = 0; c < TO + 3; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      step();
    end
    vecs++;
    if (seen || timeout_err !== 1'b1) begin
      errs++;
      $display("FAIL issue_ignore: ov_seen=%b te=%b want 0 1", seen, timeout_err);
    end
    apply_reset();
    launch(b, cd, TO);
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b1 || timeout_err !== 1'b0) begin
      errs++;
      $display("FAIL cmp_on_limit: ov=%b te=%b want 1 0", out_valid, timeout_err);
    end
    step();
    collect(1'b0);
    vecs++;
    if (!done || !stream_ok(cd) || timeout_err !== 1'b0) begin
      errs++;
      $display("FAIL limit_stream: got %p te=%b want %p 0", got_q, timeout_err, cd);
    end
  endtask

  task automatic test_reset_mid();
    batch_t b  = rand_batch();
    batch_t cd = sorted(b);
    bit bad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = word_t'($urandom);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL mid_release: busy=%b rdy=%b want 0 1", busy, in_ready);
    end
    step();
    load_batch(b);
    @(negedge clk);
    vecs++;
    if (write_en !== 1'b1 || !wd_ok(b)) begin
      errs++;
      $display("FAIL mid_fresh: we=%b wd=%p want 1 %p", write_en, write_data, b);
    end
    step();
    compare_en = 1'b1;
    compare_data = cd;
    step();
    compare_en = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid || write_en || busy) bad = 1'b1;
      step();
    end
    out_ready = 1'b0;
    vecs++;
    if (bad) begin
      errs++;
      $display("FAIL mid_drain_abort: activity after reset");
    end
  endtask

  task automatic test_random();
    bit oe = 1'b0;
    bit te = 1'b0;
    apply_reset();
    for (int it = 0; it < 30; it++) begin
      batch_t b = rand_batch();
      batch_t cd = ($urandom_range(0, 3) == 0) ? rand_batch() : sorted(b);
      int d = $urandom_range(1, TO + 2);
      load_batch(b);
      @(negedge clk);
      vecs++;
      if (write_en !== 1'b1 || !wd_ok(b)) begin
        errs++;
        $display("FAIL rnd%0d_issue: we=%b wd=%p want 1 %p", it, write_en, write_data, b);
      end
      step();
      for (int c = 1; c < d; c++) step();
      compare_en = 1'b1;
      compare_data = cd;
      step();
      compare_en = 1'b0;
      if (d <= TO) begin
        collect(1'b1);
        oe = oe | viol_n(cd, DC);
        vecs++;
        if (!done || !stream_ok(cd)) begin
          errs++;
          $display("FAIL rnd%0d_stream: got %p want %p", it, got_q, cd);
        end
      end else begin
        te = 1'b1;
        @(negedge clk);
        vecs++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errs++;
          $display("FAIL rnd%0d_drop: ov=%b rdy=%b want 0 1", it, out_valid, in_ready);
        end
        step();
      end
      @(negedge clk);
      vecs++;
      if (order_err !== oe || timeout_err !== te) begin
        errs++;
        $display("FAIL rnd%0d_flags: oe=%b te=%b want %b %b",
                 it, order_err, timeout_err, oe, te);
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < DC; i++) compare_data[i] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_order();
    test_timeout();
    test_issue_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sort_seq_ctrl.md
SORT_SEQ_CTRL -- requirements
Module: sort_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width of each sort word.
REQ-002 SHALL have parameter DATA_CNT, default 16: words per sort batch, ≥2.
REQ-003 SHALL have parameter COM_STYLE, default "UP": expected result order, "UP" (ascending) or "DOWN" (descending).
REQ-004 SHALL have parameter TIMEOUT, default 1023: maximum WAIT cycles before abort, ≥1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: an input word is offered.
REQ-008 SHALL have port in_ready, output, 1 bit: controller accepts an input word.
REQ-009 SHALL have port in_data, input, DATA_WIDTH bits: input word.
REQ-010 SHALL have port write_en, output, 1 bit: one-cycle launch pulse to the sorter.
REQ-011 SHALL have port write_data, output, unpacked array of DATA_CNT x DATA_WIDTH: batch presented to the sorter.
REQ-012 SHALL have port compare_en, input, 1 bit: sorter result valid.
REQ-013 SHALL have port compare_data, input, unpacked array of DATA_CNT x DATA_WIDTH: sorted result.
REQ-014 SHALL have port out_valid, output, 1 bit: a result word is offered.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the result word.
REQ-016 SHALL have port out_data, output, DATA_WIDTH bits: result word.
REQ-017 SHALL have port out_last, output, 1 bit: marks the final word of the batch.
REQ-018 SHALL have port busy, output, 1 bit: a batch is in progress.
REQ-019 SHALL have port order_err, output, 1 bit: sticky flag, result order violation.
REQ-020 SHALL have port timeout_err, output, 1 bit: sticky flag, sorter timeout.

Function
REQ-021 SHALL implement FSM states LOAD, ISSUE, WAIT, DRAIN.
REQ-022 SHALL accept a word on in_valid && in_ready, with in_ready=1 only in LOAD.
REQ-023 SHALL store the word accepted with load index k into write_data[k], for k = 0..DATA_CNT-1.
REQ-024 SHALL go LOAD→ISSUE on the accept with index DATA_CNT-1.
REQ-025 SHALL assert write_en=1 for exactly the single ISSUE cycle, then go to WAIT.
REQ-026 SHALL hold write_data stable from ISSUE until compare_en is accepted or the batch times out.
REQ-027 SHALL sample compare_en only in WAIT and ignore it in all other states, including the ISSUE cycle.
REQ-028 SHALL, on compare_en in WAIT, capture all of compare_data into the result buffer and go to DRAIN.
REQ-029 SHALL make out_valid=1 from the first DRAIN cycle, with out_data = result[j] and j starting at 0.
REQ-030 SHALL advance j on out_valid && out_ready, and hold out_data and out_last stable while out_ready=0.
REQ-031 SHALL assert out_last=1 when j==DATA_CNT-1.
REQ-032 SHALL go DRAIN→LOAD on the out_last handshake, clearing the load and out indices.
REQ-033 SHALL compare each accepted out word after the first against the previous one, unsigned.
REQ-034 SHALL set order_err=1 if the word is less than the previous one for "UP", or greater for "DOWN"; equal values are legal.
REQ-035 SHALL not check order across batch boundaries.
REQ-036 SHALL clear the timeout counter in ISSUE and increment it each WAIT cycle without compare_en.
REQ-037 SHALL, when the counter reaches TIMEOUT, set timeout_err=1, return to LOAD and clear the load index; the batch is dropped and no out words are emitted.
REQ-038 SHALL give compare_en priority when compare_en and timeout occur in the same cycle: no error, go to DRAIN.
REQ-039 SHALL hold order_err and timeout_err at 1 until reset.
REQ-040 SHALL drive busy=1 whenever state≠LOAD or the load index ≠0.

Reset
REQ-041 SHALL, with rst_n low at a clock edge, set state=LOAD and clear the load index, out index, timeout counter, write_data, the result buffer, write_en, order_err and timeout_err.
REQ-042 SHALL drive in_ready=1 and out_valid=0, out_last=0, busy=0 from the first cycle after reset release.
REQ-043 SHALL abort a partial load or drain on reset mid-batch, with no write_en pulse or out word afterwards.

Verification (DATA_CNT=4, DATA_WIDTH=8, TIMEOUT=8)
REQ-044 Bench SHALL cover: load 3,1,2,0 → write_en pulse of 1 cycle, the cycle after the 4th accept, with write_data={3,1,2,0}; compare_en 2 cycles later with {0,1,2,3} → out 0,1,2,3, out_last on 3, order_err=0, back to LOAD.
REQ-045 Bench SHALL cover: out_ready toggled 1,0,0,1 during drain → out_data held during stalls and each word emitted exactly once.
REQ-046 Bench SHALL cover: compare_data {0,2,1,3} with "UP" → order_err=1 after the 3rd out handshake, remaining sticky through the next clean batch.
REQ-047 Bench SHALL cover: no compare_en after ISSUE → timeout_err=1 after 8 WAIT cycles, state LOAD, no out_valid; compare_en arriving later is ignored.
REQ-048 Bench SHALL cover: compare_en in the ISSUE cycle, then none → ignored and the timeout path is taken; compare_en on the 8th WAIT cycle → DRAIN with timeout_err=0.
REQ-049 Bench SHALL cover: rst_n low after 2 accepts → busy=0 and in_ready=1 after release; the next 4 accepts form a fresh batch.
